// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for an FFT core: opens a FRAME_LEN-cycle load window per frame,
// waits for the core's done strobe (with timeout), then idles GAP_CYCLES before the next frame.
module fft_frame_sequencer #(
    parameter int FRAME_LEN  = 32,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [7:0]                   frame_count,
    input  logic                         abort,
    input  logic                         fft_done,
    output logic                         load_en,
    output logic                         frame_start,
    output logic [$clog2(FRAME_LEN)-1:0] sample_idx,
    output logic                         busy,
    output logic                         seq_done,
    output logic                         aborted,
    output logic                         timeout_err
);

    localparam int IW      = $clog2(FRAME_LEN);
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      remaining, rem_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [IW-1:0]   idx_nxt;
    logic            load_nxt, fs_nxt, busy_nxt, sd_nxt, ab_nxt, to_nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            remaining   <= '0;
            cnt         <= '0;
            load_en     <= 1'b0;
            frame_start <= 1'b0;
            sample_idx  <= '0;
            busy        <= 1'b0;
            seq_done    <= 1'b0;
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            remaining   <= rem_nxt;
            cnt         <= cnt_nxt;
            load_en     <= load_nxt;
            frame_start <= fs_nxt;
            sample_idx  <= idx_nxt;
            busy        <= busy_nxt;
            seq_done    <= sd_nxt;
            aborted     <= ab_nxt;
            timeout_err <= to_nxt;
        end
    end

    // Outputs are computed for the next state and registered alongside it.
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        cnt_nxt   = cnt;
        idx_nxt   = '0;
        load_nxt  = 1'b0;
        fs_nxt    = 1'b0;
        sd_nxt    = 1'b0;
        ab_nxt    = 1'b0;
        to_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    rem_nxt   = frame_count;
                    cnt_nxt   = '0;
                    state_nxt = LOAD;
                    load_nxt  = 1'b1;
                    fs_nxt    = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                    ab_nxt    = 1'b1;
                end else if (sample_idx == IDX_LAST) begin
                    state_nxt = WAIT_DONE;
                    cnt_nxt   = '0;
                end else begin
                    idx_nxt  = sample_idx + 1'b1;
                    load_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    ab_nxt    = 1'b1;
                end else if (fft_done) begin
                    if (remaining == 8'd1) begin
                        state_nxt = IDLE;
                        sd_nxt    = 1'b1;
                        rem_nxt   = '0;
                    end else begin
                        // remaining == 0 means continuous mode and is left untouched
                        if (remaining > 8'd1) begin
                            rem_nxt = remaining - 8'd1;
                        end
                        cnt_nxt = '0;
                        if (GAP_CYCLES == 0) begin
                            state_nxt = LOAD;
                            load_nxt  = 1'b1;
                            fs_nxt    = 1'b1;
                        end else begin
                            state_nxt = GAP;
                        end
                    end
                end else if (cnt == TO_LAST) begin
                    state_nxt = IDLE;
                    to_nxt    = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                    ab_nxt    = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = LOAD;
                    load_nxt  = 1'b1;
                    fs_nxt    = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: per-scenario expected timelines built from frame arithmetic,
// compared cycle by cycle against the DUT outputs.
module tb_fft_frame_sequencer;

    localparam int FL  = 32;
    localparam int GAP = 4;
    localparam int TO  = 1024;
    localparam int IW  = $clog2(FL);
    localparam int H   = 4096;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    frame_count = '0;
    logic          abort = 1'b0;
    logic          fft_done = 1'b0;
    logic          load_en, frame_start, busy, seq_done, aborted, timeout_err;
    logic [IW-1:0] sample_idx;

    fft_frame_sequencer #(.FRAME_LEN(FL), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .start(start), .frame_count(frame_count),
        .abort(abort), .fft_done(fft_done), .load_en(load_en),
        .frame_start(frame_start), .sample_idx(sample_idx), .busy(busy),
        .seq_done(seq_done), .aborted(aborted), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected outputs and driven inputs, indexed by cycle from the start request
    bit e_ld[H], e_fs[H], e_sd[H], e_ab[H], e_to[H], e_busy[H];
    int e_idx[H];
    bit i_start[H], i_done[H], i_abort[H];
    int dl[4];
    int endc;
    int len;
    bit timed_out;

    task automatic chk(input string tag, input logic [31:0] obs, input int want, input int c);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, c, obs, want);
        end
    endtask

    // Lay out the frames of one sequence on a timeline: LOAD, WAIT_DONE, GAP, strobes.
    task automatic build(input int n, input bit xstart);
        int t, w, d, nf;
        for (int i = 0; i < H; i++) begin
            e_ld[i] = 0; e_fs[i] = 0; e_sd[i] = 0; e_ab[i] = 0; e_to[i] = 0;
            e_busy[i] = 0; e_idx[i] = 0; i_start[i] = 0; i_done[i] = 0; i_abort[i] = 0;
        end
        i_start[0] = 1;
        timed_out = 0;
        nf = (n == 0) ? 3 : n;
        t = 1;
        endc = 0;
        for (int k = 0; k < nf; k++) begin
            e_fs[t] = 1;
            for (int j = 0; j < FL; j++) begin
                e_ld[t+j] = 1; e_idx[t+j] = j; e_busy[t+j] = 1;
            end
            if (k == 0) i_done[t+5] = 1;
            w = t + FL;
            if (dl[k] >= TO) begin
                for (int j = 0; j < TO; j++) e_busy[w+j] = 1;
                e_to[w+TO] = 1;
                endc = w + TO;
                timed_out = 1;
                break;
            end
            d = w + dl[k];
            for (int j = w; j <= d; j++) e_busy[j] = 1;
            i_done[d] = 1;
            if (xstart && k == 0) i_start[w] = 1;
            if (n != 0 && k == nf - 1) begin
                e_sd[d+1] = 1;
                endc = d + 1;
            end else begin
                for (int j = 1; j <= GAP; j++) e_busy[d+j] = 1;
                t = d + GAP + 1;
                endc = t;
            end
        end
        len = endc + 3;
    endtask

    // Abort during a busy cycle: everything after it collapses to a lone aborted strobe.
    task automatic add_abort(input int a);
        i_abort[a] = 1;
        for (int c = a + 1; c < H; c++) begin
            e_ld[c] = 0; e_fs[c] = 0; e_sd[c] = 0; e_ab[c] = 0; e_to[c] = 0;
            e_busy[c] = 0; e_idx[c] = 0;
        end
        e_ab[a+1] = 1;
        endc = a + 1;
        len = endc + 3;
    endtask

    task automatic run(input int n, input string name);
        int fs_seen, sd_seen, fs_want, sd_want;
        fs_seen = 0; sd_seen = 0; fs_want = 0; sd_want = 0;
        frame_count = 8'(n);
        for (int c = 0; c < len - 1; c++) begin
            start = i_start[c]; abort = i_abort[c]; fft_done = i_done[c];
            @(posedge clk); #1;
            chk({name, ".load_en"},     {31'd0, load_en},     int'(e_ld[c+1]),   c + 1);
            chk({name, ".frame_start"}, {31'd0, frame_start}, int'(e_fs[c+1]),   c + 1);
            chk({name, ".sample_idx"},  32'(sample_idx),      e_idx[c+1],        c + 1);
            chk({name, ".busy"},        {31'd0, busy},        int'(e_busy[c+1]), c + 1);
            chk({name, ".seq_done"},    {31'd0, seq_done},    int'(e_sd[c+1]),   c + 1);
            chk({name, ".aborted"},     {31'd0, aborted},     int'(e_ab[c+1]),   c + 1);
            chk({name, ".timeout_err"}, {31'd0, timeout_err}, int'(e_to[c+1]),   c + 1);
            if (frame_start === 1'b1) fs_seen++;
            if (seq_done === 1'b1) sd_seen++;
            fs_want += int'(e_fs[c+1]);
            sd_want += int'(e_sd[c+1]);
        end
        start = 0; abort = 0; fft_done = 0;
        chk({name, ".fs_count"}, 32'(fs_seen), fs_want, len);
        chk({name, ".sd_count"}, 32'(sd_seen), sd_want, len);
    endtask

    task automatic idle_check(input string name);
        chk({name, ".busy"},    {31'd0, busy},    0, 0);
        chk({name, ".aborted"}, {31'd0, aborted}, 0, 0);
        chk({name, ".load_en"}, {31'd0, load_en}, 0, 0);
    endtask

    initial begin
        int n, a;
        bit do_abort, xs;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst.load_en",     {31'd0, load_en},     0, 0);
        chk("rst.frame_start", {31'd0, frame_start}, 0, 0);
        chk("rst.sample_idx",  32'(sample_idx),      0, 0);
        chk("rst.busy",        {31'd0, busy},        0, 0);
        chk("rst.seq_done",    {31'd0, seq_done},    0, 0);
        chk("rst.aborted",     {31'd0, aborted},     0, 0);
        chk("rst.timeout_err", {31'd0, timeout_err}, 0, 0);

        // single frame, start on the first edge after reset release, done 7 cycles into WAIT
        rstn = 1;
        dl = '{7, 0, 0, 0};
        build(1, 0);
        run(1, "single");

        // three frames with a stray start inside the first WAIT_DONE
        for (int k = 0; k < 4; k++) dl[k] = $urandom_range(0, 20);
        build(3, 1);
        run(3, "three");

        // timeout on the first of two frames
        dl = '{TO, 0, 0, 0};
        build(2, 0);
        run(2, "timeout");

        // fft_done on the last allowed WAIT_DONE cycle
        dl = '{TO - 1, 0, 0, 0};
        build(1, 0);
        run(1, "late_done");

        // abort while sample_idx = 10, then a normal frame
        dl = '{3, 3, 0, 0};
        build(2, 0);
        add_abort(11);
        run(2, "abort_load");
        dl = '{2, 0, 0, 0};
        build(1, 0);
        run(1, "rearm");

        // abort together with fft_done
        dl = '{5, 5, 0, 0};
        build(2, 0);
        add_abort(1 + FL + 5);
        run(2, "abort_done");

        // abort and start+abort while idle are ignored
        abort = 1;
        @(posedge clk); #1;
        idle_check("idle_abort");
        start = 1; frame_count = 8'd1;
        @(posedge clk); #1;
        idle_check("idle_start_abort");
        start = 0; abort = 0;

        // reset in the middle of LOAD
        start = 1; frame_count = 8'd2;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #1;
        rstn = 0;
        @(posedge clk); #1;
        chk("rst_load.load_en",     {31'd0, load_en},     0, 0);
        chk("rst_load.frame_start", {31'd0, frame_start}, 0, 0);
        chk("rst_load.sample_idx",  32'(sample_idx),      0, 0);
        chk("rst_load.busy",        {31'd0, busy},        0, 0);
        chk("rst_load.strobes",     {29'd0, seq_done, aborted, timeout_err}, 0, 0);
        rstn = 1;

        // continuous mode, stopped by abort
        for (int k = 0; k < 4; k++) dl[k] = $urandom_range(0, 15);
        build(0, 0);
        add_abort($urandom_range(1, endc - 1));
        run(0, "continuous");

        // randomized sequences
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 4);
            for (int k = 0; k < 4; k++)
                dl[k] = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 30);
            do_abort = ($urandom_range(0, 1) == 1);
            xs = (n != 0) && !do_abort;
            build(n, xs);
            if (n == 0 && !timed_out) do_abort = 1;
            if (do_abort) begin
                a = $urandom_range(1, endc - 1);
                add_abort(a);
            end
            run(n, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  FRAME_LEN  32  samples per frame; load window length in cycles, >=2
  GAP_CYCLES  4  idle cycles between frames, >=0
  TIMEOUT  1024  maximum cycles to wait for fft_done, >=2
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all logic on rising edge
  rstn  in  1  synchronous active-low reset
  start  in  1  begin a sequence; sampled only in IDLE
  frame_count  in  8  frames to run; 0 = continuous until abort; latched on accepted start
  abort  in  1  stop the sequence at once
  fft_done  in  1  one-cycle completion strobe from the FFT core
  load_en  out  1  sample-load window to the FFT input buffer
  frame_start  out  1  one-cycle strobe on the first load cycle of each frame
  sample_idx  out  $clog2(FRAME_LEN)  index of the current sample in the load window
  busy  out  1  high in every state except IDLE
  seq_done  out  1  one-cycle strobe when the last frame's fft_done arrives
  aborted  out  1  one-cycle strobe on an abort exit
  timeout_err  out  1  one-cycle strobe on a timeout exit

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, LOAD, WAIT_DONE, GAP.
REQ-004 All outputs SHALL be registered; no output SHALL depend combinationally on an input.
REQ-005 IDLE with start=1 SHALL latch frame_count into a remaining counter, clear the timeout counter, and enter LOAD the next cycle.
REQ-006 On the first LOAD cycle: load_en=1, frame_start=1, sample_idx=0.
REQ-007 LOAD SHALL last exactly FRAME_LEN cycles, with sample_idx incrementing by 1 per cycle from 0 to FRAME_LEN-1; load_en SHALL stay high throughout.
REQ-008 The cycle after sample_idx=FRAME_LEN-1, the block SHALL enter WAIT_DONE with load_en=0 and sample_idx=0.
REQ-009 WAIT_DONE SHALL count cycles from 0; fft_done=1 SHALL end the frame.
REQ-010 At frame end with remaining=1: pulse seq_done for one cycle and go to IDLE.
REQ-011 At frame end with remaining>1: decrement remaining; with remaining=0: leave it unchanged (continuous mode).
REQ-012 After REQ-011, the block SHALL go to GAP for GAP_CYCLES cycles, then to LOAD; if GAP_CYCLES=0 it SHALL go from WAIT_DONE directly to LOAD.
REQ-013 If TIMEOUT cycles pass in WAIT_DONE without fft_done: pulse timeout_err for one cycle and go to IDLE, with no seq_done.
REQ-014 abort=1 in any non-IDLE state SHALL force IDLE the next cycle: load_en=0, sample_idx=0, aborted=1 for one cycle, no seq_done.
REQ-015 abort SHALL win over a simultaneous fft_done or timeout expiry; in that case only aborted pulses.
REQ-016 abort in IDLE SHALL be ignored, and no pulse SHALL be generated.
REQ-017 start outside IDLE SHALL be ignored; start in IDLE together with abort SHALL be ignored, and the block SHALL stay in IDLE.
REQ-018 fft_done outside WAIT_DONE SHALL be ignored.
REQ-019 After seq_done, timeout_err or aborted, the block SHALL rearm; a later start in IDLE SHALL begin a new sequence.
REQ-020 sample_idx and the timeout counter SHALL never wrap past FRAME_LEN-1 and TIMEOUT-1 respectively.

Reset
REQ-021 While rstn=0 at a rising clk edge, the state SHALL go to IDLE and the remaining and timeout counters SHALL clear.
REQ-022 Reset values SHALL be: load_en=0, frame_start=0, sample_idx=0, busy=0, seq_done=0, aborted=0, timeout_err=0.
REQ-023 Reset asserted mid-LOAD SHALL drop load_en on the next edge, with no strobe output.
REQ-024 The first start SHALL be accepted on the first edge after rstn returns high.

Verification
REQ-025 Single frame: frame_count=1, start at cycle T -> frame_start at T+1; load_en high T+1..T+32, sample_idx 0..31; fft_done at T+40 -> seq_done at T+41, busy low at T+41.
REQ-026 Three frames, GAP_CYCLES=4: each fft_done followed by 4 idle cycles, then frame_start; exactly 3 frame_start pulses and 1 seq_done.
REQ-027 Timeout: frame_count=2, fft_done never asserted -> timeout_err exactly 1024 cycles after entering WAIT_DONE; block back in IDLE; 1 frame_start total.
REQ-028 Abort mid-LOAD at sample_idx=10 -> next cycle load_en=0, sample_idx=0, aborted=1; no seq_done; a later start yields a normal frame.
REQ-029 Collisions: abort and fft_done in the same cycle -> aborted only; start asserted during WAIT_DONE -> no effect on the frame count.
REQ-030 Continuous mode: frame_count=0, fft_done returned every frame -> frames repeat indefinitely, never seq_done; abort terminates.
